// File: rtl/hazard_forward_ctrl_pkg.sv
// hazard_forward_ctrl_pkg: forwarding-select and FSM encodings shared by the hazard controller.
package hazard_forward_ctrl_pkg;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] S_INIT   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FREEZE = 2'd2;

    typedef struct packed {
        logic [4:0] rd;
        logic       rw;
    } stage_t;
endpackage

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// hazard_forward_ctrl_fwd_select: picks the forwarding source for one EX operand; MEM beats WB, $0 never forwards.
module hazard_forward_ctrl_fwd_select
    import hazard_forward_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic [4:0] mem_rd,
    input  logic       mem_rw,
    input  logic [4:0] wb_rd,
    input  logic       wb_rw,
    output logic [1:0] sel
);
    always_comb
        sel = (mem_rw && mem_rd != 5'd0 && mem_rd == src) ? FWD_MEM :
              (wb_rw && wb_rd != 5'd0 && wb_rd == src)    ? FWD_WB  : FWD_REG;
endmodule

// File: rtl/hazard_forward_ctrl.sv
// hazard_forward_ctrl: forwarding selects, load-use stall, redirect flush and memory-wait freeze for the 5-stage core.
module hazard_forward_ctrl
    import hazard_forward_ctrl_pkg::*;
#(
    parameter int RESET_BUBBLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs_ID,
    input  logic [4:0]       rt_ID,
    input  logic [4:0]       rd_ID,
    input  logic             uses_rs_ID,
    input  logic             uses_rt_ID,
    input  logic             regwrite_ID,
    input  logic             memread_ID,
    input  logic             redirect_EX,
    input  logic             mem_stall,
    output logic [1:0]       sel_A,
    output logic [1:0]       sel_B,
    output logic             stall_IF,
    output logic             stall_ID,
    output logic             flush_ID,
    output logic             flush_EX,
    output logic             freeze,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);
    localparam int IW = (RESET_BUBBLES > 1) ? $clog2(RESET_BUBBLES + 1) : 1;

    logic [1:0]    state;
    logic [IW-1:0] init_cnt;
    logic [4:0]    ex_rs, ex_rt, ex_rd;
    logic          ex_rw, ex_mr;
    stage_t        mem_q, wb_q;
    logic          run, lu, redirect, lu_stall;

    // FREEZE releases into a RUN evaluation, so both states share the same output decode
    assign run      = state != S_INIT;
    assign lu       = ex_mr && ex_rd != 5'd0 &&
                      ((uses_rs_ID && rs_ID == ex_rd) || (uses_rt_ID && rt_ID == ex_rd));
    assign freeze   = run && mem_stall;
    assign redirect = run && !mem_stall && redirect_EX;
    assign lu_stall = run && !mem_stall && !redirect_EX && lu;
    assign stall_IF = lu_stall;
    assign stall_ID = lu_stall;
    assign flush_ID = !run || redirect;
    assign flush_EX = flush_ID || lu_stall;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state    <= S_INIT;
            init_cnt <= IW'(RESET_BUBBLES);
        end else if (state == S_INIT) begin
            init_cnt <= init_cnt - IW'(1);
            if (init_cnt == IW'(1))
                state <= S_RUN;
        end else
            state <= mem_stall ? S_FREEZE : S_RUN;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            ex_rs <= 5'd0;
            ex_rt <= 5'd0;
            ex_rd <= 5'd0;
            ex_rw <= 1'b0;
            ex_mr <= 1'b0;
            mem_q <= '0;
            wb_q  <= '0;
        end else if (!freeze) begin
            ex_rs <= uses_rs_ID ? rs_ID : 5'd0;
            ex_rt <= uses_rt_ID ? rt_ID : 5'd0;
            ex_rd <= rd_ID;
            ex_rw <= regwrite_ID && !flush_EX;
            ex_mr <= memread_ID && !flush_EX;
            mem_q <= '{rd: ex_rd, rw: ex_rw};
            wb_q  <= mem_q;
        end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((freeze || lu_stall) && stall_cnt != '1)
                stall_cnt <= stall_cnt + CNT_W'(1);
            if (redirect && flush_cnt != '1)
                flush_cnt <= flush_cnt + CNT_W'(1);
        end

    hazard_forward_ctrl_fwd_select u_sel_a (
        .src    (ex_rs),
        .mem_rd (mem_q.rd),
        .mem_rw (mem_q.rw),
        .wb_rd  (wb_q.rd),
        .wb_rw  (wb_q.rw),
        .sel    (sel_A)
    );

    hazard_forward_ctrl_fwd_select u_sel_b (
        .src    (ex_rt),
        .mem_rd (mem_q.rd),
        .mem_rw (mem_q.rw),
        .wb_rd  (wb_q.rd),
        .wb_rw  (wb_q.rw),
        .sel    (sel_B)
    );
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// tb_hazard_forward_ctrl: directed program snippets then random traffic, checked against an instruction-level pipeline model.
module tb_hazard_forward_ctrl;
    localparam int RB  = 2;
    localparam int CW  = 6;
    localparam int MAX = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [4:0]    rs_ID = '0, rt_ID = '0, rd_ID = '0;
    logic          uses_rs_ID = 0, uses_rt_ID = 0, regwrite_ID = 0, memread_ID = 0;
    logic          redirect_EX = 0, mem_stall = 0;
    logic [1:0]    sel_A, sel_B;
    logic          stall_IF, stall_ID, flush_ID, flush_EX, freeze;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int checks = 0;
    int errors = 0;

    // in-flight instructions: 0 = EX, 1 = MEM, 2 = WB
    typedef struct {
        logic [4:0] rs, rt, rd;
        logic       wr, ld;
    } ins_t;
    ins_t pipe [3];
    int   init_left, m_stall, m_flush;

    hazard_forward_ctrl #(.RESET_BUBBLES(RB), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rs_ID(rs_ID), .rt_ID(rt_ID), .rd_ID(rd_ID),
        .uses_rs_ID(uses_rs_ID), .uses_rt_ID(uses_rt_ID), .regwrite_ID(regwrite_ID),
        .memread_ID(memread_ID), .redirect_EX(redirect_EX), .mem_stall(mem_stall),
        .sel_A(sel_A), .sel_B(sel_B), .stall_IF(stall_IF), .stall_ID(stall_ID),
        .flush_ID(flush_ID), .flush_EX(flush_EX), .freeze(freeze),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [1:0] fwd(input logic [4:0] x);
        if (x == 0) return 2'b00;
        if (pipe[1].wr && pipe[1].rd == x) return 2'b01;
        if (pipe[2].wr && pipe[2].rd == x) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) pipe[i] = '{rs: 0, rt: 0, rd: 0, wr: 0, ld: 0};
        init_left = RB;
        m_stall   = 0;
        m_flush   = 0;
    endtask

    // one clock: drive ID/EX inputs, check every output against the model, advance the model across the edge
    task automatic step(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic urs, input logic urt, input logic rw, input logic mr,
                        input logic rdr, input logic ms);
        logic ini, lu, efr, efl, est;
        rs_ID = rs; rt_ID = rt; rd_ID = rd;
        uses_rs_ID = urs; uses_rt_ID = urt; regwrite_ID = rw; memread_ID = mr;
        redirect_EX = rdr; mem_stall = ms;
        #1;
        ini = init_left > 0;
        lu  = pipe[0].ld && pipe[0].rd != 0 &&
              ((urs && rs == pipe[0].rd) || (urt && rt == pipe[0].rd));
        efr = !ini && ms;
        efl = !ini && !ms && rdr;
        est = !ini && !ms && !rdr && lu;
        chk("sel_A", 32'(sel_A), 32'(fwd(pipe[0].rs)));
        chk("sel_B", 32'(sel_B), 32'(fwd(pipe[0].rt)));
        chk("stall_IF", 32'(stall_IF), 32'(est));
        chk("stall_ID", 32'(stall_ID), 32'(est));
        chk("flush_ID", 32'(flush_ID), 32'(ini || efl));
        chk("flush_EX", 32'(flush_EX), 32'(ini || efl || est));
        chk("freeze", 32'(freeze), 32'(efr));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        chk("flush_cnt", 32'(flush_cnt), 32'(m_flush));
        if (!efr) begin
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = '{rs: urs ? rs : 5'd0, rt: urt ? rt : 5'd0, rd: rd,
                        wr: rw && !(ini || efl || est), ld: mr && !(ini || efl || est)};
        end
        if (ini) init_left--;
        if ((efr || est) && m_stall < MAX) m_stall++;
        if (efl && m_flush < MAX) m_flush++;
        @(posedge clk);
        #1;
    endtask

    task automatic nop(input logic rdr, input logic ms);
        step(5'd0, 5'd0, 5'd0, 0, 0, 0, 0, rdr, ms);
    endtask

    // asserts reset between edges and checks the INIT outputs before any clock can act
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_flush_ID", 32'(flush_ID), 32'd1);
        chk("rst_flush_EX", 32'(flush_EX), 32'd1);
        chk("rst_stall_IF", 32'(stall_IF), 32'd0);
        chk("rst_stall_ID", 32'(stall_ID), 32'd0);
        chk("rst_freeze", 32'(freeze), 32'd0);
        chk("rst_sel_A", 32'(sel_A), 32'd0);
        chk("rst_sel_B", 32'(sel_B), 32'd0);
        chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(flush_cnt), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        // two reset bubbles, then quiet
        nop(0, 0);
        nop(0, 0);
        chk("init_done_flush_ID", 32'(flush_ID), 32'd0);
        nop(0, 0);

        // add $3,$1,$2 ; sub $4,$3,$5
        step(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
        step(5'd3, 5'd5, 5'd4, 1, 1, 1, 0, 0, 0);
        chk("t2_fwd_mem", 32'(sel_A), 32'd1);
        // add ; nop ; sub
        step(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
        nop(0, 0);
        step(5'd3, 5'd5, 5'd4, 1, 1, 1, 0, 0, 0);
        chk("t2_fwd_wb", 32'(sel_A), 32'd2);
        // write to $0 then read $0
        step(5'd1, 5'd2, 5'd0, 1, 1, 1, 0, 0, 0);
        step(5'd0, 5'd0, 5'd4, 1, 1, 1, 0, 0, 0);
        chk("t2_zero_A", 32'(sel_A), 32'd0);
        chk("t2_zero_B", 32'(sel_B), 32'd0);

        // add $3 ; add $3 ; or $6,$3,$3
        step(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
        step(5'd4, 5'd5, 5'd3, 1, 1, 1, 0, 0, 0);
        step(5'd3, 5'd3, 5'd6, 1, 1, 1, 0, 0, 0);
        chk("t3_sel_A", 32'(sel_A), 32'd1);
        chk("t3_sel_B", 32'(sel_B), 32'd1);

        // lw $3,0($1) ; add $4,$3,$3 (ID holds for the stall, so add is presented twice)
        step(5'd1, 5'd0, 5'd3, 1, 0, 1, 1, 0, 0);
        step(5'd3, 5'd3, 5'd4, 1, 1, 1, 0, 0, 0);
        chk("t4_stall_cnt", 32'(stall_cnt), 32'd1);
        step(5'd3, 5'd3, 5'd4, 1, 1, 1, 0, 0, 0);
        chk("t4_sel_A", 32'(sel_A), 32'd2);
        chk("t4_sel_B", 32'(sel_B), 32'd2);

        // load-use coinciding with a redirect: redirect wins
        step(5'd1, 5'd0, 5'd3, 1, 0, 1, 1, 0, 0);
        step(5'd3, 5'd3, 5'd4, 1, 1, 1, 0, 1, 0);
        chk("t5_flush_cnt", 32'(flush_cnt), 32'd1);
        chk("t5_stall_cnt", 32'(stall_cnt), 32'd1);

        // three-cycle freeze with a redirect held throughout
        step(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
        step(5'd3, 5'd3, 5'd6, 1, 1, 1, 0, 0, 0);
        repeat (3) nop(1, 1);
        chk("t6_stall_cnt", 32'(stall_cnt), 32'd4);
        chk("t6_sel_held", 32'(sel_A), 32'd1);
        nop(1, 0);
        chk("t6_flush_cnt", 32'(flush_cnt), 32'd2);
        nop(0, 0);

        // reset asserted during a freeze
        step(5'd1, 5'd2, 5'd3, 1, 1, 1, 0, 0, 0);
        step(5'd3, 5'd3, 5'd6, 1, 1, 1, 0, 0, 0);
        nop(1, 1);
        chk("t6_pre_rst_sel", 32'(sel_A), 32'd1);
        do_reset();
        nop(1, 0);
        nop(1, 0);

        // random traffic over a small register set so hazards are frequent; counters reach saturation
        for (int i = 0; i < 600; i++) begin
            if (i == 300) do_reset();
            step(5'($urandom_range(3)), 5'($urandom_range(3)), 5'($urandom_range(3)),
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 1'($urandom_range(1)), $urandom_range(7) == 0, $urandom_range(3) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
